// File: rtl/matrix_pkg.sv
// Shared constants, FSM state type and element-indexing helpers for the
// sequential 3x3 matrix product.
package matrix_pkg;

  localparam int unsigned ELEM_W = 16;
  localparam int unsigned DIM    = 3;
  localparam int unsigned ACC_W  = 34;
  localparam int unsigned PROD_W = 2 * ELEM_W;
  localparam int unsigned NELEM  = DIM * DIM;
  localparam int unsigned MAT_W  = NELEM * ELEM_W;
  localparam int unsigned IDX_W  = 4;

  localparam logic [1:0] IDX_LAST = 2'(DIM - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Bit offset of element (row,col) inside a row-major packed matrix.
  function automatic int unsigned elem_lsb(input logic [1:0] row, input logic [1:0] col);
    return ELEM_W * (DIM * 32'(row) + 32'(col));
  endfunction

  // Element number of (row,col) in row-major order.
  function automatic logic [IDX_W-1:0] elem_idx(input logic [1:0] row, input logic [1:0] col);
    return IDX_W'(DIM * 32'(row) + 32'(col));
  endfunction

endpackage

// File: rtl/mat_mac16.sv
// Combinational multiply-accumulate: acc_next = acc + a*b (unsigned).
module mat_mac16
  import matrix_pkg::*;
(
  input  logic [ACC_W-1:0]  acc,
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic [ACC_W-1:0]  acc_next
);

  logic [PROD_W-1:0] prod;

  // Full-width unsigned product widened into the accumulator.
  always_comb begin
    prod     = PROD_W'(a) * PROD_W'(b);
    acc_next = acc + ACC_W'(prod);
  end

endmodule

// File: rtl/matrix_product_seq.sv
// Sequential 3x3 matrix product P = A x B using one time-multiplexed MAC.
// One partial product per cycle, row-major element order, 27 cycles per run.
module matrix_product_seq
  import matrix_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MAT_W-1:0] a_mat,
  input  logic [MAT_W-1:0] b_mat,
  output logic [MAT_W-1:0] p_mat,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  state_t                        state;
  logic [NELEM-1:0][ELEM_W-1:0]  a_q;
  logic [NELEM-1:0][ELEM_W-1:0]  b_q;
  logic [NELEM-1:0][ELEM_W-1:0]  p_q;
  logic [ACC_W-1:0]              acc;
  logic [ACC_W-1:0]              acc_next;
  logic [1:0]                    i;
  logic [1:0]                    j;
  logic [1:0]                    k;
  logic [ELEM_W-1:0]             a_op;
  logic [ELEM_W-1:0]             b_op;

  // Operand selection: A[i][k] and B[k][j] from the latched copies.
  always_comb begin
    a_op = a_q[elem_idx(i, k)];
    b_op = b_q[elem_idx(k, j)];
  end

  mat_mac16 u_mac (
    .acc      (acc),
    .a        (a_op),
    .b        (b_op),
    .acc_next (acc_next)
  );

  assign p_mat = p_q;

  // Control FSM, index counters, accumulator, result register and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      acc   <= '0;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a_mat;
            b_q   <= b_mat;
            acc   <= '0;
            ovf   <= 1'b0;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (k == IDX_LAST) begin
            p_q[elem_idx(i, j)] <= acc_next[ELEM_W-1:0];
            if (|acc_next[ACC_W-1:ELEM_W]) begin
              ovf <= 1'b1;
            end
            acc <= '0;
            k   <= '0;
            if (j == IDX_LAST) begin
              j <= '0;
              if (i == IDX_LAST) begin
                i     <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= IDLE;
              end else begin
                i <= i + 2'd1;
              end
            end else begin
              j <= j + 2'd1;
            end
          end else begin
            acc <= acc_next;
            k   <= k + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_product_seq.sv
// Directed self-checking bench for matrix_product_seq.
module tb_matrix_product_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [143:0] a_mat;
  logic [143:0] b_mat;
  logic [143:0] p_mat;
  logic         busy;
  logic         done;
  logic         ovf;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  matrix_product_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_mat (a_mat),
    .b_mat (b_mat),
    .p_mat (p_mat),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [143:0] mk(input logic [15:0] e0, e1, e2, e3, e4, e5, e6, e7, e8);
    return {e8, e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  // Present operands and pulse start for one edge; scramble inputs afterwards.
  task automatic launch(input logic [143:0] a, input logic [143:0] b);
    a_mat = a;
    b_mat = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_mat = '1;
    b_mat = '1;
  endtask

  // Cycles until done is seen (0 when the bound expires).
  task automatic wait_done(output int lat);
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic [143:0] a, input logic [143:0] b,
                     input logic [143:0] exp_p, input logic exp_ovf);
    int lat;
    launch(a, b);
    check({tag, " busy"}, 144'(busy), 144'(1));
    wait_done(lat);
    check({tag, " latency"}, 144'(lat), 144'(27));
    check({tag, " p_mat"}, p_mat, exp_p);
    check({tag, " ovf"}, 144'(ovf), 144'(exp_ovf));
    check({tag, " busy@done"}, 144'(busy), 144'(0));
    @(posedge clk);
    #1;
    check({tag, " done pulse"}, 144'(done), 144'(0));
    check({tag, " p_mat held"}, p_mat, exp_p);
  endtask

  logic [143:0] ident, b19, ones, lb_a, lb_b, lb_p, ov_a, ov_b, ov_p;

  initial begin
    int lat;
    int ndone;
    int done_at;

    ident = mk(16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1);
    b19   = mk(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9);
    ones  = mk(16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1);
    lb_a  = mk(16'h0080, 16'h0010, 16'h0080, 16'h0008, 16'h0002, 16'h0001,
               16'h0002, 16'h0010, 16'h0002);
    lb_b  = mk(16'd4, 16'd2, 16'd1, 16'd1, 16'd1, 16'd32, 16'd4, 16'd2, 16'd512);
    // Row 0 col 2 is 128+512+65536 = 66176, wraps to 640 and raises ovf.
    lb_p  = mk(16'h0410, 16'd528, 16'd640, 16'd38, 16'd20, 16'd584,
               16'd32, 16'd24, 16'd1538);
    ov_a  = mk(16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    ov_b  = mk(16'd2, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    ov_p  = mk(16'hFFFE, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);

    rst_n = 1'b0;
    start = 1'b0;
    a_mat = '0;
    b_mat = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset p_mat", p_mat, '0);
    check("reset busy", 144'(busy), 144'(0));
    check("reset done", 144'(done), 144'(0));
    check("reset ovf", 144'(ovf), 144'(0));

    run("identity", ident, b19, b19, 1'b0);
    run("loopback", lb_a, lb_b, lb_p, 1'b1);
    run("ones", ones, ones, mk(16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3), 1'b0);
    run("overflow", ov_a, ov_b, ov_p, 1'b1);
    run("ovf clear", ones, ones, mk(16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3), 1'b0);

    // start pulses during RUN must be ignored.
    launch(lb_a, lb_b);
    ndone   = 0;
    done_at = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (done_at == 0) done_at = c;
        check("mid-start p_mat", p_mat, lb_p);
      end
      start = (c == 5 || c == 20);
    end
    start = 1'b0;
    check("mid-start done count", 144'(ndone), 144'(1));
    check("mid-start done cycle", 144'(done_at), 144'(27));

    // start held high through done: next run is accepted right after done.
    a_mat = ident;
    b_mat = b19;
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(lat);
    check("held first latency", 144'(lat), 144'(27));
    check("held first p_mat", p_mat, b19);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("held restart busy", 144'(busy), 144'(1));
    wait_done(lat);
    check("held second latency", 144'(lat), 144'(27));
    check("held second p_mat", p_mat, b19);

    // Asynchronous reset in the middle of a run.
    launch(lb_a, lb_b);
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset p_mat", p_mat, '0);
    check("midreset busy", 144'(busy), 144'(0));
    check("midreset done", 144'(done), 144'(0));
    check("midreset ovf", 144'(ovf), 144'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("midreset no done", 144'(ndone), 144'(0));
    run("post-reset", lb_a, lb_b, lb_p, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
